// File: rtl/axil_demux_if.sv
// axil_demux_if: bundles the upstream AXI4-Lite slave port (s0_axi_*) and the
// flattened NUM_M downstream master ports (m_axi_*) of axil_demux.
//   slave  modport : the demux's view (accepts s0 requests, drives m_* requests)
//   master modport : the surrounding system's view (drives s0 requests,
//                    answers on m_*)
// Downstream vectors carry port i at slice [i*W +: W]; per-port handshake
// bits are one bit per port.
`timescale 1ns/1ps
interface axil_demux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 2,
    parameter int NUM_M      = 4
);
    logic [ADDR_WIDTH-1:0]         s0_axi_awaddr;
    logic                          s0_axi_awvalid;
    logic                          s0_axi_awready;
    logic [DATA_WIDTH-1:0]         s0_axi_wdata;
    logic [DATA_WIDTH/8-1:0]       s0_axi_wstrb;
    logic                          s0_axi_wvalid;
    logic                          s0_axi_wready;
    logic [RESP_WIDTH-1:0]         s0_axi_bresp;
    logic                          s0_axi_bvalid;
    logic                          s0_axi_bready;
    logic [ADDR_WIDTH-1:0]         s0_axi_araddr;
    logic                          s0_axi_arvalid;
    logic                          s0_axi_arready;
    logic [DATA_WIDTH-1:0]         s0_axi_rdata;
    logic [RESP_WIDTH-1:0]         s0_axi_rresp;
    logic                          s0_axi_rvalid;
    logic                          s0_axi_rready;

    logic [NUM_M*ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic [NUM_M-1:0]              m_axi_awvalid;
    logic [NUM_M-1:0]              m_axi_awready;
    logic [NUM_M*DATA_WIDTH-1:0]   m_axi_wdata;
    logic [NUM_M*DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic [NUM_M-1:0]              m_axi_wvalid;
    logic [NUM_M-1:0]              m_axi_wready;
    logic [NUM_M*RESP_WIDTH-1:0]   m_axi_bresp;
    logic [NUM_M-1:0]              m_axi_bvalid;
    logic [NUM_M-1:0]              m_axi_bready;
    logic [NUM_M*ADDR_WIDTH-1:0]   m_axi_araddr;
    logic [NUM_M-1:0]              m_axi_arvalid;
    logic [NUM_M-1:0]              m_axi_arready;
    logic [NUM_M*DATA_WIDTH-1:0]   m_axi_rdata;
    logic [NUM_M*RESP_WIDTH-1:0]   m_axi_rresp;
    logic [NUM_M-1:0]              m_axi_rvalid;
    logic [NUM_M-1:0]              m_axi_rready;

    modport slave (
        input  s0_axi_awaddr, s0_axi_awvalid, output s0_axi_awready,
        input  s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid, output s0_axi_wready,
        output s0_axi_bresp, s0_axi_bvalid, input s0_axi_bready,
        input  s0_axi_araddr, s0_axi_arvalid, output s0_axi_arready,
        output s0_axi_rdata, s0_axi_rresp, s0_axi_rvalid, input s0_axi_rready,
        output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
    );

    modport master (
        output s0_axi_awaddr, s0_axi_awvalid, input s0_axi_awready,
        output s0_axi_wdata, s0_axi_wstrb, s0_axi_wvalid, input s0_axi_wready,
        input  s0_axi_bresp, s0_axi_bvalid, output s0_axi_bready,
        output s0_axi_araddr, s0_axi_arvalid, input s0_axi_arready,
        input  s0_axi_rdata, s0_axi_rresp, s0_axi_rvalid, output s0_axi_rready,
        input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid, output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
    );
endinterface

// File: rtl/axil_demux.sv
// axil_demux: AXI4-Lite 1-to-NUM_M address demultiplexer.
// Port index = addr >> REGION_LOG2; indices >= NUM_M complete locally with
// DECERR and bump a saturating 16-bit counter. Read and write paths are
// independent FSMs, one outstanding transaction each. All outputs registered.
// Ports:
//   s0_axi_aclk     clock, rising edge
//   s0_axi_aresetn  asynchronous active-low reset
//   bus             axil_demux_if.slave (s0_axi_* upstream, m_axi_* downstream)
//   decerr_count    saturating count of DECERR responses (read + write)
//
// state    | meaning
// W_IDLE   | accepting AW and W independently, in any order
// W_FWD    | selected port awvalid/wvalid up until each handshakes
// W_BWAIT  | selected port bready up, waiting for its bvalid
// W_RESP   | s0 bvalid up, bresp held until s0 bready
// R_IDLE   | arready up, waiting for AR
// R_FWD    | selected port arvalid up until arready
// R_WAIT   | selected port rready up, waiting for its rvalid
// R_RESP   | s0 rvalid up, rdata/rresp held until s0 rready
`timescale 1ns/1ps
module axil_demux #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int RESP_WIDTH  = 2,
    parameter int NUM_M       = 4,
    parameter int REGION_LOG2 = 4
) (
    input  logic          s0_axi_aclk,
    input  logic          s0_axi_aresetn,
    axil_demux_if.slave   bus,
    output logic [15:0]   decerr_count
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_BWAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_RESP} r_state_e;

    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a >> REGION_LOG2) < 32'(NUM_M);
    endfunction

    function automatic logic [SEL_W-1:0] port_of(input logic [ADDR_WIDTH-1:0] a);
        return SEL_W'(a >> REGION_LOG2);
    endfunction

    function automatic logic [NUM_M-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [NUM_M-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (SEL_W'(i) == s) v[i] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- write path ----------------
    w_state_e                    w_state_q, w_state_d;
    logic                        aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [ADDR_WIDTH-1:0]       awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0]           wstrb_q, wstrb_d;
    logic [SEL_W-1:0]            w_sel_q, w_sel_d;
    logic                        awready_q, awready_d, wready_q, wready_d;
    logic                        bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0]       bresp_q, bresp_d;
    logic [NUM_M-1:0]            m_awvalid_q, m_awvalid_d, m_wvalid_q, m_wvalid_d;
    logic [NUM_M-1:0]            m_bready_q, m_bready_d;
    logic [NUM_M*ADDR_WIDTH-1:0] m_awaddr_q, m_awaddr_d;
    logic [NUM_M*DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [NUM_M*STRB_W-1:0]     m_wstrb_q, m_wstrb_d;
    logic                        aw_hs, w_hs, w_dec;

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            w_state_q   <= W_IDLE;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            w_sel_q     <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            m_awvalid_q <= '0;
            m_wvalid_q  <= '0;
            m_bready_q  <= '0;
            m_awaddr_q  <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
        end else begin
            w_state_q   <= w_state_d;
            aw_got_q    <= aw_got_d;
            w_got_q     <= w_got_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            w_sel_q     <= w_sel_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            m_awvalid_q <= m_awvalid_d;
            m_wvalid_q  <= m_wvalid_d;
            m_bready_q  <= m_bready_d;
            m_awaddr_q  <= m_awaddr_d;
            m_wdata_q   <= m_wdata_d;
            m_wstrb_q   <= m_wstrb_d;
        end
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_got_d    = aw_got_q;
        w_got_d     = w_got_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        w_sel_d     = w_sel_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        m_awvalid_d = m_awvalid_q;
        m_wvalid_d  = m_wvalid_q;
        m_bready_d  = m_bready_q;
        m_awaddr_d  = m_awaddr_q;
        m_wdata_d   = m_wdata_q;
        m_wstrb_d   = m_wstrb_q;
        w_dec       = 1'b0;
        aw_hs       = bus.s0_axi_awvalid & awready_q;
        w_hs        = bus.s0_axi_wvalid & wready_q;

        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) awaddr_d = bus.s0_axi_awaddr;
                if (w_hs) begin
                    wdata_d = bus.s0_axi_wdata;
                    wstrb_d = bus.s0_axi_wstrb;
                end
                aw_got_d  = aw_got_q | aw_hs;
                w_got_d   = w_got_q | w_hs;
                // each ready drops right after its own handshake
                awready_d = ~aw_got_d;
                wready_d  = ~w_got_d;
                if (aw_got_d && w_got_d) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    if (is_mapped(awaddr_d)) begin
                        w_sel_d     = port_of(awaddr_d);
                        m_awvalid_d = onehot(w_sel_d);
                        m_wvalid_d  = onehot(w_sel_d);
                        m_awaddr_d  = '0;
                        m_wdata_d   = '0;
                        m_wstrb_d   = '0;
                        for (int i = 0; i < NUM_M; i++) begin
                            if (SEL_W'(i) == w_sel_d) begin
                                m_awaddr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = awaddr_d;
                                m_wdata_d[i*DATA_WIDTH +: DATA_WIDTH]  = wdata_d;
                                m_wstrb_d[i*STRB_W +: STRB_W]          = wstrb_d;
                            end
                        end
                        w_state_d = W_FWD;
                    end else begin
                        bresp_d   = RESP_DECERR;
                        bvalid_d  = 1'b1;
                        w_dec     = 1'b1;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_FWD: begin
                m_awvalid_d = m_awvalid_q & ~bus.m_axi_awready;
                m_wvalid_d  = m_wvalid_q & ~bus.m_axi_wready;
                if (m_awvalid_d == '0 && m_wvalid_d == '0) begin
                    m_bready_d = onehot(w_sel_q);
                    w_state_d  = W_BWAIT;
                end
            end
            W_BWAIT: begin
                if ((m_bready_q & bus.m_axi_bvalid) != '0) begin
                    for (int i = 0; i < NUM_M; i++) begin
                        if (SEL_W'(i) == w_sel_q) bresp_d = bus.m_axi_bresp[i*RESP_WIDTH +: RESP_WIDTH];
                    end
                    m_bready_d = '0;
                    bvalid_d   = 1'b1;
                    w_state_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.s0_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------- read path ----------------
    r_state_e                    r_state_q, r_state_d;
    logic [SEL_W-1:0]            r_sel_q, r_sel_d;
    logic                        arready_q, arready_d;
    logic                        rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0]       rresp_q, rresp_d;
    logic [NUM_M-1:0]            m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
    logic [NUM_M*ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
    logic                        ar_hs, r_dec;

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            r_state_q   <= R_IDLE;
            r_sel_q     <= '0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            m_arvalid_q <= '0;
            m_rready_q  <= '0;
            m_araddr_q  <= '0;
        end else begin
            r_state_q   <= r_state_d;
            r_sel_q     <= r_sel_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            m_arvalid_q <= m_arvalid_d;
            m_rready_q  <= m_rready_d;
            m_araddr_q  <= m_araddr_d;
        end
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_sel_d     = r_sel_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        m_arvalid_d = m_arvalid_q;
        m_rready_d  = m_rready_q;
        m_araddr_d  = m_araddr_q;
        r_dec       = 1'b0;
        ar_hs       = bus.s0_axi_arvalid & arready_q;

        unique case (r_state_q)
            R_IDLE: begin
                // arready also rises here on the first edge after reset
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    if (is_mapped(bus.s0_axi_araddr)) begin
                        r_sel_d     = port_of(bus.s0_axi_araddr);
                        m_arvalid_d = onehot(r_sel_d);
                        m_araddr_d  = '0;
                        for (int i = 0; i < NUM_M; i++) begin
                            if (SEL_W'(i) == r_sel_d) m_araddr_d[i*ADDR_WIDTH +: ADDR_WIDTH] = bus.s0_axi_araddr;
                        end
                        r_state_d = R_FWD;
                    end else begin
                        rdata_d   = '0;
                        rresp_d   = RESP_DECERR;
                        rvalid_d  = 1'b1;
                        r_dec     = 1'b1;
                        r_state_d = R_RESP;
                    end
                end
            end
            R_FWD: begin
                m_arvalid_d = m_arvalid_q & ~bus.m_axi_arready;
                if (m_arvalid_d == '0) begin
                    m_rready_d = onehot(r_sel_q);
                    r_state_d  = R_WAIT;
                end
            end
            R_WAIT: begin
                if ((m_rready_q & bus.m_axi_rvalid) != '0) begin
                    for (int i = 0; i < NUM_M; i++) begin
                        if (SEL_W'(i) == r_sel_q) begin
                            rdata_d = bus.m_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                            rresp_d = bus.m_axi_rresp[i*RESP_WIDTH +: RESP_WIDTH];
                        end
                    end
                    m_rready_d = '0;
                    rvalid_d   = 1'b1;
                    r_state_d  = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.s0_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------- DECERR counter (both paths may hit in one cycle) ----------------
    logic [15:0] decerr_q, decerr_d;
    logic [1:0]  dec_inc;
    logic [16:0] dec_sum;

    always_comb begin
        dec_inc  = {1'b0, w_dec} + {1'b0, r_dec};
        dec_sum  = {1'b0, decerr_q} + {15'b0, dec_inc};
        decerr_d = dec_sum[16] ? 16'hFFFF : dec_sum[15:0];
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) decerr_q <= '0;
        else                 decerr_q <= decerr_d;
    end

    assign decerr_count       = decerr_q;
    assign bus.s0_axi_awready = awready_q;
    assign bus.s0_axi_wready  = wready_q;
    assign bus.s0_axi_bresp   = bresp_q;
    assign bus.s0_axi_bvalid  = bvalid_q;
    assign bus.s0_axi_arready = arready_q;
    assign bus.s0_axi_rdata   = rdata_q;
    assign bus.s0_axi_rresp   = rresp_q;
    assign bus.s0_axi_rvalid  = rvalid_q;
    assign bus.m_axi_awaddr   = m_awaddr_q;
    assign bus.m_axi_awvalid  = m_awvalid_q;
    assign bus.m_axi_wdata    = m_wdata_q;
    assign bus.m_axi_wstrb    = m_wstrb_q;
    assign bus.m_axi_wvalid   = m_wvalid_q;
    assign bus.m_axi_bready   = m_bready_q;
    assign bus.m_axi_araddr   = m_araddr_q;
    assign bus.m_axi_arvalid  = m_arvalid_q;
    assign bus.m_axi_rready   = m_rready_q;
endmodule

// File: tb/tb_axil_demux.sv
// tb_axil_demux: directed-vector bench for axil_demux (NUM_M=4, 16-byte regions).
// Downstream ports answer AW/W/AR with zero wait; B and R responders wait a
// programmable number of cycles after seeing bready/rready.
`timescale 1ns/1ps
module tb_axil_demux;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 2;
    localparam int NM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] decerr_count;
    int          n_checks = 0;
    int          n_fail = 0;

    int          b_delay = 0;
    int          r_delay = 0;
    logic [RW-1:0] r_resp_val = '0;
    logic [DW-1:0] r_data_val = '0;

    always #5 clk = ~clk;

    axil_demux_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_M(NM)) bus_if ();

    axil_demux #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_M(NM), .REGION_LOG2(4)) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_aresetn (rst_n),
        .bus            (bus_if),
        .decerr_count   (decerr_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (!bus_if.s0_axi_bvalid && n < 100) begin
            tick();
            n++;
        end
        if (!bus_if.s0_axi_bvalid) chk("b_timeout", {63'b0, bus_if.s0_axi_bvalid}, 64'd1);
    endtask

    task automatic wait_r(output int n);
        n = 0;
        while (!bus_if.s0_axi_rvalid && n < 100) begin
            tick();
            n++;
        end
        if (!bus_if.s0_axi_rvalid) chk("r_timeout", {63'b0, bus_if.s0_axi_rvalid}, 64'd1);
    endtask

    task automatic b_accept();
        bus_if.s0_axi_bready = 1'b1;
        tick();
        bus_if.s0_axi_bready = 1'b0;
    endtask

    task automatic r_accept();
        bus_if.s0_axi_rready = 1'b1;
        tick();
        bus_if.s0_axi_rready = 1'b0;
    endtask

    // B responder
    initial begin
        int wc;
        wc = 0;
        bus_if.m_axi_bvalid = '0;
        bus_if.m_axi_bresp  = '0;
        forever begin
            tick();
            if (bus_if.m_axi_bready == '0) begin
                bus_if.m_axi_bvalid = '0;
                wc = 0;
            end else if (bus_if.m_axi_bvalid == '0) begin
                if (wc >= b_delay) bus_if.m_axi_bvalid = bus_if.m_axi_bready;
                else wc++;
            end
        end
    end

    // R responder: port i returns r_data_val ^ i
    initial begin
        int wc;
        wc = 0;
        bus_if.m_axi_rvalid = '0;
        bus_if.m_axi_rdata  = '0;
        bus_if.m_axi_rresp  = '0;
        forever begin
            tick();
            if (bus_if.m_axi_rready == '0) begin
                bus_if.m_axi_rvalid = '0;
                wc = 0;
            end else if (bus_if.m_axi_rvalid == '0) begin
                if (wc >= r_delay) begin
                    for (int i = 0; i < NM; i++) begin
                        bus_if.m_axi_rdata[i*DW +: DW] = r_data_val ^ DW'(i);
                        bus_if.m_axi_rresp[i*RW +: RW] = r_resp_val;
                    end
                    bus_if.m_axi_rvalid = bus_if.m_axi_rready;
                end else wc++;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nb, nr, k;
        bus_if.s0_axi_awaddr  = '0;
        bus_if.s0_axi_awvalid = 1'b0;
        bus_if.s0_axi_wdata   = '0;
        bus_if.s0_axi_wstrb   = '0;
        bus_if.s0_axi_wvalid  = 1'b0;
        bus_if.s0_axi_bready  = 1'b0;
        bus_if.s0_axi_araddr  = '0;
        bus_if.s0_axi_arvalid = 1'b0;
        bus_if.s0_axi_rready  = 1'b0;
        bus_if.m_axi_awready  = '1;
        bus_if.m_axi_wready   = '1;
        bus_if.m_axi_arready  = '1;

        // reset values
        repeat (3) tick();
        chk("rst_awready", {63'b0, bus_if.s0_axi_awready}, 64'd0);
        chk("rst_arready", {63'b0, bus_if.s0_axi_arready}, 64'd0);
        chk("rst_bvalid",  {63'b0, bus_if.s0_axi_bvalid}, 64'd0);
        chk("rst_rvalid",  {63'b0, bus_if.s0_axi_rvalid}, 64'd0);
        chk("rst_decerr",  {48'b0, decerr_count}, 64'd0);
        chk("rst_m_awaddr", {32'b0, bus_if.m_axi_awaddr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_cycle_awready", {63'b0, bus_if.s0_axi_awready}, 64'd0);
        tick();
        chk("first_edge_awready", {63'b0, bus_if.s0_axi_awready}, 64'd1);
        chk("first_edge_wready",  {63'b0, bus_if.s0_axi_wready}, 64'd1);
        chk("first_edge_arready", {63'b0, bus_if.s0_axi_arready}, 64'd1);

        // mapped write to 0x14 -> port 1, zero-wait slave
        bus_if.s0_axi_awaddr  = 8'h14;
        bus_if.s0_axi_wdata   = 32'h1234_5678;
        bus_if.s0_axi_wstrb   = 4'hF;
        bus_if.s0_axi_awvalid = 1'b1;
        bus_if.s0_axi_wvalid  = 1'b1;
        tick();
        bus_if.s0_axi_awvalid = 1'b0;
        bus_if.s0_axi_wvalid  = 1'b0;
        chk("w14_awready_drop", {63'b0, bus_if.s0_axi_awready}, 64'd0);
        chk("w14_m_awvalid", {60'b0, bus_if.m_axi_awvalid}, 64'h2);
        chk("w14_m_wvalid",  {60'b0, bus_if.m_axi_wvalid}, 64'h2);
        chk("w14_m_awaddr",  {32'b0, bus_if.m_axi_awaddr}, 64'h0000_1400);
        chk("w14_m_wdata",   {32'b0, bus_if.m_axi_wdata[63:32]}, 64'h1234_5678);
        chk("w14_m_wstrb",   {48'b0, bus_if.m_axi_wstrb}, 64'h00F0);
        wait_b(nb);
        chk("w14_b_latency", 64'(nb), 64'd2);
        chk("w14_bresp", {62'b0, bus_if.s0_axi_bresp}, 64'd0);
        chk("w14_m_awvalid_off", {60'b0, bus_if.m_axi_awvalid}, 64'd0);
        b_accept();
        chk("w14_bvalid_off", {63'b0, bus_if.s0_axi_bvalid}, 64'd0);
        chk("w14_awready_back", {63'b0, bus_if.s0_axi_awready}, 64'd1);

        // W first, AW three cycles later to 0x30 -> port 3
        bus_if.s0_axi_wdata  = 32'hCAFE_0003;
        bus_if.s0_axi_wstrb  = 4'h3;
        bus_if.s0_axi_wvalid = 1'b1;
        tick();
        bus_if.s0_axi_wvalid = 1'b0;
        chk("w30_wready_drop", {63'b0, bus_if.s0_axi_wready}, 64'd0);
        chk("w30_awready_hold", {63'b0, bus_if.s0_axi_awready}, 64'd1);
        tick();
        tick();
        chk("w30_wready_low", {63'b0, bus_if.s0_axi_wready}, 64'd0);
        chk("w30_no_m_wvalid", {60'b0, bus_if.m_axi_wvalid}, 64'd0);
        bus_if.s0_axi_awaddr  = 8'h30;
        bus_if.s0_axi_awvalid = 1'b1;
        tick();
        bus_if.s0_axi_awvalid = 1'b0;
        chk("w30_m_awvalid", {60'b0, bus_if.m_axi_awvalid}, 64'h8);
        chk("w30_m_wvalid",  {60'b0, bus_if.m_axi_wvalid}, 64'h8);
        chk("w30_m_awaddr",  {32'b0, bus_if.m_axi_awaddr}, 64'h3000_0000);
        chk("w30_m_wdata",   {32'b0, bus_if.m_axi_wdata[127:96]}, 64'hCAFE_0003);
        chk("w30_m_wstrb",   {48'b0, bus_if.m_axi_wstrb}, 64'h3000);
        wait_b(nb);
        chk("w30_bresp", {62'b0, bus_if.s0_axi_bresp}, 64'd0);
        b_accept();

        // unmapped read 0x48 -> local DECERR
        bus_if.s0_axi_araddr  = 8'h48;
        bus_if.s0_axi_arvalid = 1'b1;
        tick();
        bus_if.s0_axi_arvalid = 1'b0;
        chk("r48_rvalid", {63'b0, bus_if.s0_axi_rvalid}, 64'd1);
        chk("r48_rresp",  {62'b0, bus_if.s0_axi_rresp}, 64'd3);
        chk("r48_rdata",  {32'b0, bus_if.s0_axi_rdata}, 64'd0);
        chk("r48_decerr", {48'b0, decerr_count}, 64'd1);
        chk("r48_no_m_arvalid", {60'b0, bus_if.m_axi_arvalid}, 64'd0);
        chk("r48_arready_low", {63'b0, bus_if.s0_axi_arready}, 64'd0);
        r_accept();
        chk("r48_rvalid_off", {63'b0, bus_if.s0_axi_rvalid}, 64'd0);
        chk("r48_arready_back", {63'b0, bus_if.s0_axi_arready}, 64'd1);

        // concurrent write 0x04 / read 0x08, slave responses delayed 5 cycles
        b_delay    = 5;
        r_delay    = 5;
        r_data_val = 32'hA5A5_0000;
        r_resp_val = 2'd0;
        bus_if.s0_axi_awaddr  = 8'h04;
        bus_if.s0_axi_wdata   = 32'h0BAD_F00D;
        bus_if.s0_axi_wstrb   = 4'hF;
        bus_if.s0_axi_araddr  = 8'h08;
        bus_if.s0_axi_awvalid = 1'b1;
        bus_if.s0_axi_wvalid  = 1'b1;
        bus_if.s0_axi_arvalid = 1'b1;
        tick();
        bus_if.s0_axi_awvalid = 1'b0;
        bus_if.s0_axi_wvalid  = 1'b0;
        bus_if.s0_axi_arvalid = 1'b0;
        chk("cc_m_awvalid", {60'b0, bus_if.m_axi_awvalid}, 64'h1);
        chk("cc_m_arvalid", {60'b0, bus_if.m_axi_arvalid}, 64'h1);
        chk("cc_m_araddr",  {32'b0, bus_if.m_axi_araddr}, 64'h0000_0008);
        nb = -1;
        nr = -1;
        for (int n = 1; n <= 100 && (nb < 0 || nr < 0); n++) begin
            tick();
            if (bus_if.s0_axi_bvalid && nb < 0) nb = n;
            if (bus_if.s0_axi_rvalid && nr < 0) nr = n;
        end
        chk("cc_b_latency", 64'(nb), 64'd7);
        chk("cc_r_latency", 64'(nr), 64'd7);
        chk("cc_bresp", {62'b0, bus_if.s0_axi_bresp}, 64'd0);
        b_accept();
        chk("cc_bvalid_off", {63'b0, bus_if.s0_axi_bvalid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("cc_rvalid_hold", {63'b0, bus_if.s0_axi_rvalid}, 64'd1);
            chk("cc_rdata_stable", {32'b0, bus_if.s0_axi_rdata}, 64'hA5A5_0000);
            tick();
        end
        chk("cc_rresp", {62'b0, bus_if.s0_axi_rresp}, 64'd0);
        r_accept();
        chk("cc_rvalid_off", {63'b0, bus_if.s0_axi_rvalid}, 64'd0);

        // slave SLVERR on read 0x2C -> port 2
        r_delay    = 0;
        r_resp_val = 2'd2;
        r_data_val = 32'h1111_2222;
        bus_if.s0_axi_araddr  = 8'h2C;
        bus_if.s0_axi_arvalid = 1'b1;
        tick();
        bus_if.s0_axi_arvalid = 1'b0;
        chk("r2c_m_arvalid", {60'b0, bus_if.m_axi_arvalid}, 64'h4);
        chk("r2c_m_araddr",  {32'b0, bus_if.m_axi_araddr}, 64'h002C_0000);
        wait_r(nr);
        chk("r2c_r_latency", 64'(nr), 64'd2);
        chk("r2c_rresp", {62'b0, bus_if.s0_axi_rresp}, 64'd2);
        chk("r2c_rdata", {32'b0, bus_if.s0_axi_rdata}, 64'h1111_2220);
        r_accept();

        // reset while waiting for B
        b_delay = 10;
        bus_if.s0_axi_awaddr  = 8'h00;
        bus_if.s0_axi_wdata   = 32'h0000_0055;
        bus_if.s0_axi_awvalid = 1'b1;
        bus_if.s0_axi_wvalid  = 1'b1;
        tick();
        bus_if.s0_axi_awvalid = 1'b0;
        bus_if.s0_axi_wvalid  = 1'b0;
        tick();
        chk("rbw_m_bready", {60'b0, bus_if.m_axi_bready}, 64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rbw_m_bready_async", {60'b0, bus_if.m_axi_bready}, 64'd0);
        chk("rbw_awready_async", {63'b0, bus_if.s0_axi_awready}, 64'd0);
        chk("rbw_m_awaddr_async", {32'b0, bus_if.m_axi_awaddr}, 64'd0);
        chk("rbw_decerr_async", {48'b0, decerr_count}, 64'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        b_delay = 0;
        tick();
        tick();
        chk("rbw_no_bvalid", {63'b0, bus_if.s0_axi_bvalid}, 64'd0);
        bus_if.s0_axi_wdata   = 32'h0000_0077;
        bus_if.s0_axi_awvalid = 1'b1;
        bus_if.s0_axi_wvalid  = 1'b1;
        tick();
        bus_if.s0_axi_awvalid = 1'b0;
        bus_if.s0_axi_wvalid  = 1'b0;
        chk("rbw_m_wdata", {32'b0, bus_if.m_axi_wdata[31:0]}, 64'h77);
        wait_b(nb);
        chk("rbw_b_latency", 64'(nb), 64'd2);
        chk("rbw_bresp", {62'b0, bus_if.s0_axi_bresp}, 64'd0);
        b_accept();

        // simultaneous DECERR streams until the counter saturates
        bus_if.s0_axi_awaddr  = 8'hF0;
        bus_if.s0_axi_araddr  = 8'hF4;
        bus_if.s0_axi_awvalid = 1'b1;
        bus_if.s0_axi_wvalid  = 1'b1;
        bus_if.s0_axi_arvalid = 1'b1;
        bus_if.s0_axi_bready  = 1'b1;
        bus_if.s0_axi_rready  = 1'b1;
        tick();
        chk("sat_double_inc", {48'b0, decerr_count}, 64'd2);
        chk("sat_bresp", {62'b0, bus_if.s0_axi_bresp}, 64'd3);
        k = 0;
        while (decerr_count != 16'hFFFF && k < 70000) begin
            tick();
            k++;
        end
        chk("sat_reach", {48'b0, decerr_count}, 64'hFFFF);
        repeat (4) tick();
        chk("sat_hold", {48'b0, decerr_count}, 64'hFFFF);
        chk("sat_no_m_awvalid", {60'b0, bus_if.m_axi_awvalid}, 64'd0);
        chk("sat_no_m_arvalid", {60'b0, bus_if.m_axi_arvalid}, 64'd0);
        bus_if.s0_axi_awvalid = 1'b0;
        bus_if.s0_axi_wvalid  = 1'b0;
        bus_if.s0_axi_arvalid = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
